// File: rtl/waveform_generator.sv
// Periodic 8-bit sample source (saw, reverse saw, triangle, square) with a programmable
// sample-rate divider; waveform changes are deferred to period boundaries.
module waveform_generator #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        wave_sel,
  input  logic [DIV_W-1:0]  freq_div,
  output logic [DATA_W-1:0] data_out,
  output logic              sample_valid,
  output logic              period_done
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] W_SAW = 2'b00;
  localparam logic [1:0] W_REV = 2'b01;
  localparam logic [1:0] W_TRI = 2'b10;
  localparam logic [1:0] W_SQR = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [DATA_W-1:0] ZERO_C     = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONE_C      = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] MAX_C      = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] MAX_M1_C   = {{(DATA_W-1){1'b1}}, 1'b0};
  localparam logic [DIV_W-1:0]  DIV_ZERO_C = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0]  DIV_ONE_C  = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t              state_r, state_nxt_s;
  logic [DIV_W-1:0]    div_cnt_r, div_cnt_nxt_s;
  logic [DATA_W-1:0]   phase_r, phase_nxt_s, step_phase_s;
  logic                dir_r, dir_nxt_s, step_dir_s;
  logic [1:0]          wave_r, wave_nxt_s;
  logic [DATA_W-1:0]   data_nxt_s;
  logic                sv_nxt_s, pd_nxt_s, tick_s;

  function automatic logic [DATA_W-1:0] map_sample(input logic [1:0] wave,
                                                   input logic [DATA_W-1:0] ph);
    logic [DATA_W-1:0] val;
    case (wave)
      W_SAW:   val = ph;
      W_REV:   val = ~ph;
      W_TRI:   val = ph;
      W_SQR:   val = ph[DATA_W-1] ? MAX_C : ZERO_C;
      default: val = ph;
    endcase
    return val;
  endfunction

  // Candidate phase/direction for the next tick; triangle turns around without repeating peaks
  always_comb begin
    step_phase_s = phase_r + ONE_C;
    step_dir_s   = dir_r;
    if (wave_r == W_TRI) begin
      if (dir_r == DIR_DOWN) begin
        step_phase_s = phase_r - ONE_C;
        if (phase_r == ONE_C) begin
          step_dir_s = DIR_UP;
        end else begin
          step_dir_s = DIR_DOWN;
        end
      end else begin
        step_phase_s = phase_r + ONE_C;
        if (phase_r == MAX_M1_C) begin
          step_dir_s = DIR_DOWN;
        end else begin
          step_dir_s = DIR_UP;
        end
      end
    end else begin
      step_phase_s = phase_r + ONE_C;
      step_dir_s   = dir_r;
    end
  end

  // Next-state and datapath update for the IDLE/RUN controller
  always_comb begin
    state_nxt_s   = state_r;
    div_cnt_nxt_s = div_cnt_r;
    phase_nxt_s   = phase_r;
    dir_nxt_s     = dir_r;
    wave_nxt_s    = wave_r;
    data_nxt_s    = data_out;
    sv_nxt_s      = 1'b0;
    pd_nxt_s      = 1'b0;
    tick_s        = 1'b0;
    case (state_r)
      IDLE: begin
        wave_nxt_s    = wave_sel;
        div_cnt_nxt_s = DIV_ZERO_C;
        if (enable) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        // >= rather than == so a freq_div lowered below the count still ticks promptly
        tick_s = (div_cnt_r >= freq_div);
        if (tick_s) begin
          div_cnt_nxt_s = DIV_ZERO_C;
          phase_nxt_s   = step_phase_s;
          dir_nxt_s     = step_dir_s;
          sv_nxt_s      = 1'b1;
          data_nxt_s    = map_sample(wave_r, step_phase_s);
          if (step_phase_s == ZERO_C) begin
            pd_nxt_s   = 1'b1;
            wave_nxt_s = wave_sel;
            dir_nxt_s  = DIR_UP;
          end else begin
            pd_nxt_s   = 1'b0;
          end
        end else begin
          div_cnt_nxt_s = div_cnt_r + DIV_ONE_C;
        end
        if (enable) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      div_cnt_r    <= DIV_ZERO_C;
      phase_r      <= ZERO_C;
      dir_r        <= DIR_UP;
      wave_r       <= W_SAW;
      data_out     <= ZERO_C;
      sample_valid <= 1'b0;
      period_done  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      div_cnt_r    <= div_cnt_nxt_s;
      phase_r      <= phase_nxt_s;
      dir_r        <= dir_nxt_s;
      wave_r       <= wave_nxt_s;
      data_out     <= data_nxt_s;
      sample_valid <= sv_nxt_s;
      period_done  <= pd_nxt_s;
    end
  end

endmodule

// File: tb/tb_waveform_generator.sv
// Bench for waveform_generator: period-position model checked every cycle plus directed
// literal checks for reset, rates, period lengths, deferred wave switch and pause.
module tb_waveform_generator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  wave_sel;
  logic [15:0] freq_div;
  logic [7:0]  data_out;
  logic        sample_valid;
  logic        period_done;

  int n_checks = 0;
  int n_pass   = 0;

  waveform_generator #(.DATA_W(8), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wave_sel(wave_sel),
    .freq_div(freq_div), .data_out(data_out), .sample_valid(sample_valid),
    .period_done(period_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: position within the current period, sample value derived from the waveform shape
  bit         m_run = 1'b0;
  int         m_cnt = 0;
  int         m_pos = 0;
  logic [1:0] m_wave = 2'b00;
  int         e_data = 0;
  bit         e_sv = 1'b0;
  bit         e_pd = 1'b0;

  function automatic int wave_val(input logic [1:0] w, input int p);
    case (w)
      2'b00:   return p;
      2'b01:   return 255 - p;
      2'b10:   return (p <= 255) ? p : 510 - p;
      default: return (p >= 128) ? 255 : 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int c, p, d;
    bit sv, pd;
    logic [1:0] w;
    if (!rst_n) begin
      m_run <= 1'b0; m_cnt <= 0; m_pos <= 0; m_wave <= 2'b00;
      e_data <= 0; e_sv <= 1'b0; e_pd <= 1'b0;
    end else begin
      c = m_cnt; p = m_pos; w = m_wave; d = e_data; sv = 1'b0; pd = 1'b0;
      if (!m_run) begin
        w = wave_sel;
        c = 0;
      end else if (c >= int'(freq_div)) begin
        c = 0;
        p = (p + 1) % ((w == 2'b10) ? 510 : 256);
        sv = 1'b1;
        d = wave_val(w, p);
        if (p == 0) begin
          pd = 1'b1;
          w = wave_sel;
        end
      end else begin
        c = c + 1;
      end
      m_run <= enable; m_cnt <= c; m_pos <= p; m_wave <= w;
      e_data <= d; e_sv <= sv; e_pd <= pd;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("data_out", int'(data_out), e_data);
    check("sample_valid", int'(sample_valid), int'(e_sv));
    check("period_done", int'(period_done), int'(e_pd));
  end

  task automatic do_reset();
    enable = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic wait_sv(input int limit, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (sample_valid) ok = 1'b1;
    end
    if (!ok) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_pd(input int limit, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (period_done) ok = 1'b1;
    end
    if (!ok) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_data(input int value, input int limit, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (int'(data_out) == value) ok = 1'b1;
    end
    if (!ok) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int cyc, ns, nff, n255, held, prev;
    bit done;
    rst_n = 1'b1; enable = 1'b0; wave_sel = 2'b00; freq_div = 16'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_data", int'(data_out), 0);
    check("reset_sv", int'(sample_valid), 0);
    rst_n = 1'b1;

    // Saw, freq_div=0: 256 samples per period, wrap sample is 0
    enable = 1'b1;
    wait_pd(600, "saw_pd1");
    check("saw_wrap_data", int'(data_out), 0);
    ns = 0; done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (sample_valid) ns++;
      if (period_done) done = 1'b1;
    end
    check("saw_period_samples", ns, 256);

    // Async reset mid-run at phase 0x37, then resume from 0
    do_reset();
    enable = 1'b1;
    wait_data(8'h37, 100, "saw_37");
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data", int'(data_out), 0);
    check("async_rst_sv", int'(sample_valid), 0);
    check("async_rst_pd", int'(period_done), 0);
    @(negedge clk); rst_n = 1'b1;
    wait_sv(10, "resume");
    check("resume_first", int'(data_out), 1);

    // Saw, freq_div=3: one sample every 4 clocks, +1 per sample
    do_reset();
    freq_div = 16'd3; enable = 1'b1;
    wait_sv(20, "div3_a");
    prev = int'(data_out); cyc = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk); cyc++;
      if (sample_valid) done = 1'b1;
    end
    check("div3_gap", cyc, 4);
    check("div3_step", int'(data_out), (prev + 1) % 256);

    // Triangle: 510 ticks per period, single 255 peak
    do_reset();
    freq_div = 16'd0; wave_sel = 2'b10; enable = 1'b1;
    wait_pd(1200, "tri_pd1");
    cyc = 0; n255 = 0; done = 1'b0;
    for (int i = 0; i < 1200 && !done; i++) begin
      @(negedge clk); cyc++;
      if (sample_valid && data_out == 8'hFF) n255++;
      if (period_done) done = 1'b1;
    end
    check("tri_period", cyc, 510);
    check("tri_peak_count", n255, 1);

    // Square: 128 high samples of 256
    do_reset();
    wave_sel = 2'b11; enable = 1'b1;
    wait_pd(600, "sq_pd1");
    ns = 0; nff = 0; done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (sample_valid) ns++;
      if (sample_valid && data_out == 8'hFF) nff++;
      if (period_done) done = 1'b1;
    end
    check("sq_high", nff, 128);
    check("sq_total", ns, 256);

    // Reverse saw starts 254, 253
    do_reset();
    wave_sel = 2'b01; enable = 1'b1;
    wait_sv(10, "rev_a");
    check("rev_first", int'(data_out), 254);
    wait_sv(10, "rev_b");
    check("rev_second", int'(data_out), 253);

    // Deferred wave switch saw->square at 0x40, then divider lowered mid-count
    do_reset();
    wave_sel = 2'b00; enable = 1'b1;
    wait_data(8'h40, 100, "sw_40");
    wave_sel = 2'b11;
    @(negedge clk);
    check("switch_deferred", int'(data_out), 8'h41);
    wait_pd(300, "sw_pd");
    check("switch_wrap", int'(data_out), 0);
    wait_data(8'hFF, 300, "sw_square_high");
    freq_div = 16'd100;
    wait_sv(120, "div100");
    repeat (50) @(negedge clk);
    freq_div = 16'd2;
    @(negedge clk);
    check("div_lowered_tick", int'(sample_valid), 1);

    // Pause holds data_out; resume continues +1
    do_reset();
    wave_sel = 2'b00; freq_div = 16'd0; enable = 1'b1;
    repeat (20) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    held = int'(data_out);
    repeat (10) @(negedge clk);
    check("pause_hold", int'(data_out), held);
    enable = 1'b1;
    wait_sv(10, "unpause");
    check("pause_resume", int'(data_out), (held + 1) % 256);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
